tl_ul_a_arbiter: RTL
====================

# tl_ul_a_arbiter

Round-robin arbiter that lets several TileLink-UL single-beat masters share one downstream A/D port, such as the port of a TLBuffer in front of a peripheral crossbar. It registers the granted A beat into a one-entry output stage and tags the source with the master index. It routes D beats back by that tag and caps outstanding requests per master. It also raises a sticky error flag on a D beat that matches no outstanding request.

## Interface
Parameters:
- NUM_M, default 2: number of masters; a power of two, at least 2. IDX_W = clog2(NUM_M).
- SRC_W, default 2: master-side source width. Downstream source width is IDX_W+SRC_W.
- ADDR_W, default 31: address width.
- DATA_W, default 64: data width. Mask width is DATA_W/8.
- MAX_OUTST, default 4: maximum in-flight A beats per master, at least 1. CNT_W = clog2(MAX_OUTST+1).

Ports (per-master fields are packed vectors, master i occupying slice i):
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- m_a_valid / m_a_ready  in / out  NUM_M each  per-master A handshake
- m_a_opcode  in  3*NUM_M  A opcode
- m_a_size  in  2*NUM_M  A size
- m_a_source  in  SRC_W*NUM_M  A source
- m_a_address  in  ADDR_W*NUM_M  A address
- m_a_mask  in  (DATA_W/8)*NUM_M  A byte mask
- m_a_data  in  DATA_W*NUM_M  A data
- m_d_valid / m_d_ready  out / in  NUM_M each  per-master D handshake
- m_d_opcode, m_d_size, m_d_source, m_d_data  out  3 / 2 / SRC_W / DATA_W  shared D payload, broadcast to all masters
- out_a_valid / out_a_ready  out / in  1 each  downstream A handshake
- out_a_opcode, out_a_size, out_a_source, out_a_address, out_a_mask, out_a_data  out  3 / 2 / IDX_W+SRC_W / ADDR_W / DATA_W/8 / DATA_W  downstream A payload
- out_d_valid / out_d_ready  in / out  1 each  downstream D handshake
- out_d_opcode, out_d_size, out_d_source, out_d_data  in  3 / 2 / IDX_W+SRC_W / DATA_W  downstream D payload
- err_unexpected_d  out  1  sticky error flag
- idle  out  1  no traffic pending or in flight

## Operation
- **Eligibility:** master i is eligible when m_a_valid[i] is high and cnt[i] < MAX_OUTST.
- **Arbitration:** round-robin. Search from (ptr+1) mod NUM_M upward with wrap. The first eligible master wins.
- **Pointer update:** ptr updates to the winner only on an accepted beat.
- **Load condition:** load = !out_a_valid || out_a_ready.
  - m_a_ready[i] = load && (winner == i) && any eligible.
  - The accepted beat is registered into the output stage.
  - out_a_source = {i, m_a_source[i]}. All other fields are copied unchanged.
- **Output stage:** out_a_valid sets on accept. It clears when out_a_ready is high and no new beat is accepted the same cycle. The payload holds stable while valid && !ready.
- **D routing (combinational):**
  - d_idx = out_d_source[IDX_W+SRC_W-1:SRC_W].
  - m_d_valid[i] = out_d_valid && d_idx == i.
  - out_d_ready = m_d_ready[d_idx].
  - m_d_source = out_d_source[SRC_W-1:0]. Opcode, size and data pass unchanged.
- **Counters cnt[i]:**
  - +1 on A accept from master i.
  - -1 on D fire (valid && ready) to master i.
  - Both in the same cycle: unchanged.
  - A D fire while cnt[i]==0 does not decrement and sets err_unexpected_d.
- **err_unexpected_d:** sticky; cleared only by reset.
- **idle** = !out_a_valid && all cnt == 0.
- **Payload legality:** not checked; opcodes and sizes pass through.

## Timing
- **Reset values:**
  - out_a_valid=0, out_a payload=0.
  - ptr=NUM_M-1, so master 0 has first priority.
  - cnt=0, err_unexpected_d=0, idle=1.
  - m_a_ready=0 is forced during reset.
- **A latency:** exactly 1 cycle from m_a accept to out_a_valid.
- **Throughput:** sustains 1 beat/cycle while out_a_ready is held high.
- **Ready dependencies:** m_a_ready depends combinationally on out_a_ready. out_a_valid never depends combinationally on any input.
- **D latency:** 0 cycles, pure combinational path.
- **Reset mid-operation:** the held A beat is dropped and counters clear. In-flight D beats after reset are flagged as unexpected.
- **Full counter:** a master at MAX_OUTST is skipped. Another eligible master wins that cycle, with no bubble.

## Structure
- **Shared package `tl_ul_pkg`:** opcode constants (Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1) and typedefs for the A and D beat payloads, parameterised by width localparams.
- **Sub-module `rr_arbiter`:** takes NUM_M requests and an advance strobe; outputs a one-hot grant and the winner index. It holds its own pointer state.
- All other logic stays in the top module.

## Test plan
- **Single master, ready high:** master 0 issues Get at address 0x1000, source 1 → out_a_valid rises the next cycle with out_a_source=3'b001. A D beat with source 3'b001 reaches master 0 only, with m_d_source=1.
- **Both masters streaming, ready high:** out_a_source index sequence is 0,1,0,1,… with no idle cycles.
- **Back-pressure:** out_a_ready held low for 5 cycles with a beat held → payload stable, both m_a_ready low. After release, the beat drains and the next beat is accepted in the same cycle.
- **Outstanding cap:** MAX_OUTST=4; master 0 issues 4 beats with no D → m_a_ready[0] stays low on the 5th request while master 1 is granted. One D beat to master 0 re-enables it.
- **Unexpected D:** D beat with source index 1 while cnt[1]==0 → err_unexpected_d=1 and cnt[1] stays 0; the flag persists until reset.
- **Async reset:** reset asserted while a beat is held → out_a_valid=0, cnt=0 and idle=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcode encodings and beat payload typedefs
// sized by the package width localparams.
package tl_ul_pkg;

  localparam int unsigned TL_ADDR_W = 31;
  localparam int unsigned TL_DATA_W = 64;
  localparam int unsigned TL_MASK_W = TL_DATA_W / 8;
  localparam int unsigned TL_SRC_W  = 3;

  typedef enum logic [2:0] {
    A_PUT_FULL_DATA    = 3'd0,
    A_PUT_PARTIAL_DATA = 3'd1,
    A_GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_MASK_W-1:0] mask;
    logic [TL_DATA_W-1:0] data;
  } tl_a_beat_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_DATA_W-1:0] data;
  } tl_d_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the slot after the last winner and
// moves its pointer only when the grant is actually taken (advance).
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Last-winner pointer; resets to N-1 so slot 0 is searched first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r <= IDX_W'(N - 1);
    end else if (advance) begin
      ptr_r <= idx;
    end
  end

  // Wrapping search; offset N wraps back onto the pointer slot itself.
  always_comb begin
    any    = 1'b0;
    idx    = {IDX_W{1'b0}};
    cand_s = {IDX_W{1'b0}};
    hit_s  = 1'b0;
    for (int off = 1; off <= N; off++) begin
      cand_s = ptr_r + IDX_W'(off);
      hit_s  = !any && req[cand_s];
      idx    = hit_s ? cand_s : idx;
      any    = any | hit_s;
    end
  end

  // One-hot view of the winner index.
  always_comb begin
    grant = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      grant[i] = any && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/tl_ul_a_arbiter.sv
// N-to-1 TileLink-UL A-channel arbiter with a one-entry registered output stage,
// source-tag based D routing, per-master outstanding caps and an unexpected-D flag.
module tl_ul_a_arbiter
  import tl_ul_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int SRC_W     = 2,
  parameter int ADDR_W    = 31,
  parameter int DATA_W    = 64,
  parameter int MAX_OUTST = 4,
  parameter int IDX_W     = $clog2(NUM_M),
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_M-1:0]              m_a_valid,
  output logic [NUM_M-1:0]              m_a_ready,
  input  logic [3*NUM_M-1:0]            m_a_opcode,
  input  logic [2*NUM_M-1:0]            m_a_size,
  input  logic [SRC_W*NUM_M-1:0]        m_a_source,
  input  logic [ADDR_W*NUM_M-1:0]       m_a_address,
  input  logic [(DATA_W/8)*NUM_M-1:0]   m_a_mask,
  input  logic [DATA_W*NUM_M-1:0]       m_a_data,
  output logic [NUM_M-1:0]              m_d_valid,
  input  logic [NUM_M-1:0]              m_d_ready,
  output logic [2:0]                    m_d_opcode,
  output logic [1:0]                    m_d_size,
  output logic [SRC_W-1:0]              m_d_source,
  output logic [DATA_W-1:0]             m_d_data,
  output logic                          out_a_valid,
  input  logic                          out_a_ready,
  output logic [2:0]                    out_a_opcode,
  output logic [1:0]                    out_a_size,
  output logic [IDX_W+SRC_W-1:0]        out_a_source,
  output logic [ADDR_W-1:0]             out_a_address,
  output logic [DATA_W/8-1:0]           out_a_mask,
  output logic [DATA_W-1:0]             out_a_data,
  input  logic                          out_d_valid,
  output logic                          out_d_ready,
  input  logic [2:0]                    out_d_opcode,
  input  logic [1:0]                    out_d_size,
  input  logic [IDX_W+SRC_W-1:0]        out_d_source,
  input  logic [DATA_W-1:0]             out_d_data,
  output logic                          err_unexpected_d,
  output logic                          idle
);

  localparam int MASK_W = DATA_W / 8;
  localparam int OSRC_W = IDX_W + SRC_W;

  logic [NUM_M-1:0] elig_s;
  logic [NUM_M-1:0] grant_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             any_s;
  logic             load_s;
  logic             accept_s;
  logic [IDX_W-1:0] d_idx_s;
  logic             d_fire_s;
  logic [NUM_M-1:0] inc_s;
  logic [NUM_M-1:0] dec_s;
  logic             all_zero_s;
  logic [CNT_W-1:0] cnt_r [NUM_M];

  // A master is eligible only while it still has headroom under the cap.
  always_comb begin
    elig_s = {NUM_M{1'b0}};
    for (int i = 0; i < NUM_M; i++) begin
      elig_s[i] = m_a_valid[i] && (cnt_r[i] < CNT_W'(MAX_OUTST));
    end
  end

  rr_arbiter #(
    .N     (NUM_M),
    .IDX_W (IDX_W)
  ) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (elig_s),
    .advance (accept_s),
    .grant   (grant_s),
    .idx     (win_idx_s),
    .any     (any_s)
  );

  assign load_s    = !out_a_valid || out_a_ready;
  assign accept_s  = load_s && any_s && !reset;
  assign m_a_ready = accept_s ? grant_s : {NUM_M{1'b0}};

  // Output stage: capture the winner's beat, tagging the source with its index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_a_valid   <= 1'b0;
      out_a_opcode  <= 3'd0;
      out_a_size    <= 2'd0;
      out_a_source  <= {OSRC_W{1'b0}};
      out_a_address <= {ADDR_W{1'b0}};
      out_a_mask    <= {MASK_W{1'b0}};
      out_a_data    <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      out_a_valid   <= 1'b1;
      out_a_opcode  <= m_a_opcode[int'(win_idx_s)*3 +: 3];
      out_a_size    <= m_a_size[int'(win_idx_s)*2 +: 2];
      out_a_source  <= {win_idx_s, m_a_source[int'(win_idx_s)*SRC_W +: SRC_W]};
      out_a_address <= m_a_address[int'(win_idx_s)*ADDR_W +: ADDR_W];
      out_a_mask    <= m_a_mask[int'(win_idx_s)*MASK_W +: MASK_W];
      out_a_data    <= m_a_data[int'(win_idx_s)*DATA_W +: DATA_W];
    end else if (out_a_ready) begin
      out_a_valid   <= 1'b0;
    end
  end

  assign d_idx_s     = out_d_source[OSRC_W-1:SRC_W];
  assign out_d_ready = m_d_ready[d_idx_s];
  assign d_fire_s    = out_d_valid && out_d_ready;
  assign m_d_opcode  = out_d_opcode;
  assign m_d_size    = out_d_size;
  assign m_d_source  = out_d_source[SRC_W-1:0];
  assign m_d_data    = out_d_data;

  // D valid is steered to the master named by the index half of the source.
  always_comb begin
    m_d_valid = {NUM_M{1'b0}};
    for (int i = 0; i < NUM_M; i++) begin
      m_d_valid[i] = out_d_valid && (d_idx_s == IDX_W'(i));
    end
  end

  // Counter strobes; a D response against an empty counter never decrements.
  always_comb begin
    inc_s      = {NUM_M{1'b0}};
    dec_s      = {NUM_M{1'b0}};
    all_zero_s = 1'b1;
    for (int i = 0; i < NUM_M; i++) begin
      inc_s[i]   = accept_s && (win_idx_s == IDX_W'(i));
      dec_s[i]   = d_fire_s && (d_idx_s == IDX_W'(i)) && (cnt_r[i] != {CNT_W{1'b0}});
      all_zero_s = all_zero_s && (cnt_r[i] == {CNT_W{1'b0}});
    end
  end

  // Outstanding counters; simultaneous inc and dec cancel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_M; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (inc_s[i] && !dec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else if (dec_s[i] && !inc_s[i]) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end
      end
    end
  end

  // Sticky flag for a D response that matches nothing in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_unexpected_d <= 1'b0;
    end else if (d_fire_s && (cnt_r[d_idx_s] == {CNT_W{1'b0}})) begin
      err_unexpected_d <= 1'b1;
    end
  end

  assign idle = !out_a_valid && all_zero_s;

endmodule
